// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, coordinate type and phase decode.
// Default timing is 800x600@72 Hz with a 50 MHz pixel clock. Coordinates
// are signed: blanking occupies the negative range and precedes the active
// area, so a full line/frame fits in 11 bits.
package vga_pkg;

  localparam int HACTIVE = 800;
  localparam int HFP     = 56;
  localparam int HSYNC   = 120;
  localparam int HBP     = 64;
  localparam int VACTIVE = 600;
  localparam int VFP     = 37;
  localparam int VSYNC   = 6;
  localparam int VBP     = 23;

  localparam int HBLANK  = HFP + HSYNC + HBP;   // 240
  localparam int VBLANK  = VFP + VSYNC + VBP;   // 66
  localparam int HTOTAL  = HACTIVE + HBLANK;    // 1040
  localparam int VTOTAL  = VACTIVE + VBLANK;    // 666

  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PH_FP,
    PH_SYNC,
    PH_BP,
    PH_ACTIVE
  } phase_e;

  // Blanking runs front porch -> sync -> back porch up to -1, so the phase
  // is found by measuring back from zero: [-bp,-1] is back porch and
  // [-(bp+sync), -bp-1] is sync; anything earlier is front porch.
  function automatic phase_e phase_of(coord_t c, int sync_w, int bp_w);
    phase_e ph;
    if (!c[COORD_W-1])                          ph = PH_ACTIVE;
    else if (c >= coord_t'(-bp_w))              ph = PH_BP;
    else if (c >= coord_t'(-(bp_w + sync_w)))   ph = PH_SYNC;
    else                                        ph = PH_FP;
    return ph;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_sync_delay.sv
// sync_delay: DEPTH-stage shift register for a small bundle of timing bits.
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset; all stages load RST_VAL
//   d_i     in   WIDTH-bit input bundle
//   q_o     out  input bundle delayed by DEPTH clocks
module sync_delay #(
  parameter int unsigned       DEPTH   = 2,
  parameter int unsigned       WIDTH   = 3,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster sequencer for the pixel datapath.
//   clk         in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   spotX       out  signed horizontal coordinate, negative in blanking
//   spotY       out  signed vertical coordinate, negative in blanking
//   hsync       out  horizontal sync, delayed by PIPE_DELAY clocks
//   vsync       out  vertical sync, delayed by PIPE_DELAY clocks
//   blank       out  1 outside active area, delayed by PIPE_DELAY clocks
//   frame_tick  out  one-cycle pulse while (spotX,spotY) = (0,0)
//   frame_cnt   out  frame counter, steps the cycle after frame_tick
module vga_timing_ctrl #(
  parameter int   HACTIVE    = vga_pkg::HACTIVE,
  parameter int   HFP        = vga_pkg::HFP,
  parameter int   HSYNC      = vga_pkg::HSYNC,
  parameter int   HBP        = vga_pkg::HBP,
  parameter int   VACTIVE    = vga_pkg::VACTIVE,
  parameter int   VFP        = vga_pkg::VFP,
  parameter int   VSYNC      = vga_pkg::VSYNC,
  parameter int   VBP        = vga_pkg::VBP,
  parameter logic HSYNC_POL  = 1'b1,
  parameter logic VSYNC_POL  = 1'b1,
  parameter int   PIPE_DELAY = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  output vga_pkg::coord_t spotX,
  output vga_pkg::coord_t spotY,
  output logic           hsync,
  output logic           vsync,
  output logic           blank,
  output logic           frame_tick,
  output logic [15:0]    frame_cnt
);

  import vga_pkg::*;

  localparam int HBLK  = HFP + HSYNC + HBP;
  localparam int VBLK  = VFP + VSYNC + VBP;
  localparam int HLAST = HACTIVE - 1;
  localparam int VLAST = VACTIVE - 1;

  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_pipe_delay
    $error("vga_timing_ctrl: PIPE_DELAY must be 1..8");
  end
  if (HACTIVE < 1 || HFP < 1 || HSYNC < 1 || HBP < 1 ||
      VACTIVE < 1 || VFP < 1 || VSYNC < 1 || VBP < 1) begin : g_bad_timing
    $error("vga_timing_ctrl: timing widths must be positive");
  end
  if (HLAST > 1023 || HBLK > 1024 || VLAST > 1023 || VBLK > 1024) begin : g_bad_range
    $error("vga_timing_ctrl: coordinate range exceeds signed 11 bits");
  end

  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic        tick_q, tick_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  phase_e      hphase, vphase;
  logic        hs_raw, vs_raw, blank_raw;
  logic [2:0]  sync_dly;

  // Line and frame wrap share the x==HLAST cycle, so the corner
  // (HLAST,VLAST) wraps both counters at once.
  always_comb begin
    x_d = x_q + coord_t'(1);
    y_d = y_q;
    if (x_q == coord_t'(HLAST)) begin
      x_d = coord_t'(-HBLK);
      if (y_q == coord_t'(VLAST)) y_d = coord_t'(-VBLK);
      else                        y_d = y_q + coord_t'(1);
    end
  end

  // Tick is registered from the next-state coordinates so it lines up
  // with the registered spotX/spotY = (0,0) cycle.
  always_comb begin
    tick_d      = (x_d == '0) && (y_d == '0);
    frame_cnt_d = frame_cnt_q;
    if (tick_q) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= coord_t'(-HBLK);
      y_q         <= coord_t'(-VBLK);
      tick_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      tick_q      <= tick_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    hphase    = phase_of(x_q, HSYNC, HBP);
    vphase    = phase_of(y_q, VSYNC, VBP);
    hs_raw    = (hphase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vs_raw    = (vphase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    blank_raw = x_q[COORD_W-1] | y_q[COORD_W-1];
  end

  sync_delay #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (3),
    .RST_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b1})
  ) u_sync_delay (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    ({hs_raw, vs_raw, blank_raw}),
    .q_o    (sync_dly)
  );

  assign spotX      = x_q;
  assign spotY      = y_q;
  assign hsync      = sync_dly[2];
  assign vsync      = sync_dly[1];
  assign blank      = sync_dly[0];
  assign frame_tick = tick_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. One full-size instance (800x600, PIPE_DELAY=2)
// and two reduced-timing instances (8x4 active, PIPE_DELAY 5 and 1) so that
// whole frames fit in a short run.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // full-size instance
  logic               rst_a = 1'b1;
  logic signed [10:0] ax, ay;
  logic               ahs, avs, abl, atk;
  logic [15:0]        acnt;

  vga_timing_ctrl #(.PIPE_DELAY(2)) dut (
    .clk(clk), .reset_n(rst_a), .spotX(ax), .spotY(ay), .hsync(ahs),
    .vsync(avs), .blank(abl), .frame_tick(atk), .frame_cnt(acnt)
  );

  // reduced instances: HBLK=7 (fp -7..-6, sync -5..-3, bp -2..-1), line 15
  // VBLK=5 (fp -5..-4, sync -3..-2, bp -1), frame 9 lines = 135 clocks
  logic               rst_s = 1'b1;
  logic signed [10:0] x5, y5, x1, y1;
  logic               hs5, vs5, bl5, tk5, hs1, vs1, bl1, tk1;
  logic [15:0]        cnt5, cnt1;

  vga_timing_ctrl #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2),
    .VACTIVE(4), .VFP(2), .VSYNC(2), .VBP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DELAY(5)
  ) dut_s5 (
    .clk(clk), .reset_n(rst_s), .spotX(x5), .spotY(y5), .hsync(hs5),
    .vsync(vs5), .blank(bl5), .frame_tick(tk5), .frame_cnt(cnt5)
  );

  vga_timing_ctrl #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2),
    .VACTIVE(4), .VFP(2), .VSYNC(2), .VBP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DELAY(1)
  ) dut_s1 (
    .clk(clk), .reset_n(rst_s), .spotX(x1), .spotY(y1), .hsync(hs1),
    .vsync(vs1), .blank(bl1), .frame_tick(tk1), .frame_cnt(cnt1)
  );

  initial begin
    int ex, ey, bad, n;
    int r1, f1, r2, f2, bl0, vsc;
    logic prev_hs;
    int ticks, tick_c, fall5, fall1, vs_lo, blo5, blo1, cbad, sbad, wraps;
    logic pb5, pb1;

    #1;
    rst_a = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge clk);

    // ---------------- full-size instance ----------------
    check_eq("rst_x", ax, -240);
    check_eq("rst_y", ay, -66);
    check_eq("rst_hsync", ahs, 0);
    check_eq("rst_vsync", avs, 0);
    check_eq("rst_blank", abl, 1);
    check_eq("rst_tick", atk, 0);
    check_eq("rst_cnt", acnt, 0);

    rst_a = 1'b1;
    ex = -240; ey = -66; bad = 0;
    r1 = -1; f1 = -1; r2 = -1; f2 = -1; bl0 = 0; vsc = 0;
    prev_hs = ahs;
    for (int i = 0; i <= 2080; i++) begin
      if (int'(ax) != ex || int'(ay) != ey) bad++;
      if (ahs && !prev_hs) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (!ahs && prev_hs) begin
        if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
      end
      prev_hs = ahs;
      if (!abl) bl0++;
      if (avs) vsc++;
      if (i == 1039) begin
        check_eq("x_before_wrap", ax, 799);
        check_eq("y_before_wrap", ay, -66);
      end
      if (i == 1040) begin
        check_eq("x_after_wrap", ax, -240);
        check_eq("y_after_wrap", ay, -65);
      end
      if (i < 2080) begin
        if (ex == 799) begin
          ex = -240;
          ey = (ey == 599) ? -66 : ey + 1;
        end else ex++;
        @(negedge clk);
      end
    end
    check_eq("coord_sweep_errs", bad, 0);
    check_eq("hsync_rise_l0", r1, 58);
    check_eq("hsync_fall_l0", f1, 178);
    check_eq("hsync_rise_l1", r2, 1098);
    check_eq("hsync_width_l1", f2 - r2, 120);
    check_eq("blank_low_in_vblank", bl0, 0);
    check_eq("vsync_high_early", vsc, 0);

    n = 0;
    while (int'(ax) != 300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_x300", ax, 300);
    check_eq("reach_x300_y", ay, -64);
    rst_a = 1'b0;
    #1;
    check_eq("midrst_x", ax, -240);
    check_eq("midrst_y", ay, -66);
    check_eq("midrst_blank", abl, 1);
    check_eq("midrst_hsync", ahs, 0);
    @(negedge clk);
    rst_a = 1'b1;
    n = 0;
    while (!atk && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_tick_latency", n, 68880);
    check_eq("tick_x", ax, 0);
    check_eq("tick_y", ay, 0);
    check_eq("blank_at_tick", abl, 1);
    @(negedge clk);
    check_eq("blank_tick_plus1", abl, 1);
    check_eq("cnt_after_tick", acnt, 1);
    check_eq("tick_one_cycle", atk, 0);
    @(negedge clk);
    check_eq("blank_tick_plus2", abl, 0);

    // ---------------- reduced instances ----------------
    check_eq("s_rst_x", x5, -7);
    check_eq("s_rst_y", y5, -5);
    check_eq("s_rst_hsync", hs5, 0);
    check_eq("s_rst_vsync", vs5, 1);
    check_eq("s_rst_blank", bl5, 1);
    check_eq("s_rst_cnt", cnt5, 0);

    rst_s = 1'b1;
    ex = -7; ey = -5;
    ticks = 0; tick_c = -1; fall5 = -1; fall1 = -1;
    vs_lo = 0; blo5 = 0; blo1 = 0; cbad = 0; sbad = 0; wraps = 0;
    pb5 = bl5; pb1 = bl1;
    for (int c = 0; c < 145; c++) begin
      if (int'(x5) != ex || int'(y5) != ey) sbad++;
      if (x5 != x1 || y5 != y1 || tk5 != tk1) cbad++;
      if (tk5) begin
        ticks++;
        tick_c = c;
        if (x5 != 0 || y5 != 0) sbad++;
      end
      if (c == 135) begin
        check_eq("s_corner_wrap_x", x5, -7);
        check_eq("s_corner_wrap_y", y5, -5);
      end
      if (!vs5) vs_lo++;
      if (!bl5) blo5++;
      if (!bl1) blo1++;
      if (pb5 && !bl5 && fall5 < 0) fall5 = c;
      if (pb1 && !bl1 && fall1 < 0) fall1 = c;
      pb5 = bl5; pb1 = bl1;
      if (ex == 7) begin
        ex = -7;
        ey = (ey == 3) ? -5 : ey + 1;
        wraps++;
      end else ex++;
      if (c < 144) @(negedge clk);
    end
    check_eq("s_coord_seq_errs", sbad, 0);
    check_eq("s_pd1_pd5_coord_diff", cbad, 0);
    check_eq("s_tick_count", ticks, 1);
    check_eq("s_tick_cycle", tick_c, 82);
    check_eq("s_blank_fall_pd5", fall5 - tick_c, 5);
    check_eq("s_blank_fall_pd1", fall1 - tick_c, 1);
    check_eq("s_vsync_active_clks", vs_lo, 30);
    check_eq("s_blank_low_pd5", blo5, 32);
    check_eq("s_blank_low_pd1", blo1, 32);
    check_eq("s_cnt_after_frame", cnt5, 1);

    n = 0;
    while (!(int'(x5) == 3 && int'(y5) == 2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("s_reach_3_2", n, 106);
    check_eq("s_cnt_before_rst", cnt5, 2);
    rst_s = 1'b0;
    #1;
    check_eq("s_midrst_x", x5, -7);
    check_eq("s_midrst_y", y5, -5);
    check_eq("s_midrst_blank", bl5, 1);
    check_eq("s_midrst_hsync", hs5, 0);
    check_eq("s_midrst_vsync", vs5, 1);
    check_eq("s_midrst_cnt", cnt5, 0);
    @(negedge clk);
    rst_s = 1'b1;
    n = 0;
    while (!tk5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("s_first_tick_latency", n, 82);

    repeat (2) @(negedge clk);
    force dut_s5.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_s5.frame_cnt_q;
    check_eq("s_cnt_preload", cnt5, 65535);
    n = 0;
    while (!tk5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("s_wrap_tick_wait", n, 132);
    check_eq("s_cnt_before_wrap", cnt5, 65535);
    @(negedge clk);
    check_eq("s_cnt_wrap", cnt5, 0);
    check_eq("s_cnt_unforced", cnt1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
